// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-access sequencer in front of the data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/loader; one 32-bit access per grant.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_v0,
    output logic        rsp_v1,
    output logic        rsp_err0,
    output logic        rsp_err1,
    output logic [31:0] rsp_data0,
    output logic [31:0] rsp_data1,
    output logic        mem_rvalid,
    output logic        mem_wvalid,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  BUSY     = 2'd1;
    localparam logic [1:0]  RESP     = 2'd2;
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 32'd4);

    logic [1:0]  state;
    logic [1:0]  state_d;
    logic        last_grant;
    logic        owner;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_err_q;
    logic [31:0] rsp_data_q;
    logic        err;
    logic        pick0;

    assign err   = (addr_q[1:0] != 2'b00) || (addr_q > MAX_ADDR);
    // Port 0 wins when alone, or on a tie when port 1 was served last.
    assign pick0 = req0 && (!req1 || last_grant);

    // Next state, grants and memory strobes.
    always_comb begin
        state_d    = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        mem_rvalid = 1'b0;
        mem_wvalid = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req0 || req1) begin
                    state_d = BUSY;
                    gnt0    = rst && pick0;
                    gnt1    = rst && !pick0;
                end
            end
            BUSY: begin
                state_d    = RESP;
                mem_rvalid = !we_q && !err;
                mem_wvalid = we_q && !err && rst;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched command and response capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= 32'h0;
        end else begin
            state <= state_d;
            if (gnt0 || gnt1) begin
                owner      <= gnt1;
                last_grant <= gnt1;
                we_q       <= gnt1 ? we1    : we0;
                addr_q     <= gnt1 ? addr1  : addr0;
                wdata_q    <= gnt1 ? wdata1 : wdata0;
            end
            if (state == BUSY) begin
                rsp_err_q  <= err;
                rsp_data_q <= (!we_q && !err) ? mem_rdata : 32'h0;
            end
        end
    end

    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;

    assign rsp_v0    = (state == RESP) && !owner;
    assign rsp_v1    = (state == RESP) && owner;
    assign rsp_err0  = rsp_v0 && rsp_err_q;
    assign rsp_err1  = rsp_v1 && rsp_err_q;
    assign rsp_data0 = rsp_v0 ? rsp_data_q : 32'h0;
    assign rsp_data1 = rsp_v1 ? rsp_data_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-level memory model, grant-order reference and
// per-port expected-response queues popped by an independent response monitor.
module tb_dmem_arbiter;

    localparam int unsigned MEM_BYTES = 16384;
    localparam logic [31:0] MAX_ADDR  = 32'(MEM_BYTES - 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rsp_v0, rsp_v1, rsp_err0, rsp_err1;
    logic [31:0] rsp_data0, rsp_data1;
    logic        mem_rvalid, mem_wvalid;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_v0(rsp_v0), .rsp_v1(rsp_v1), .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int w;
        int cyc;
    } glog_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    glog_t       glog[$];
    logic [7:0]  dmem [MEM_BYTES];
    logic [7:0]  rmem [MEM_BYTES];

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational big-endian read, write on the clock edge.
    always_comb begin
        mem_rdata = 32'hA5A5_5A5A;
        if (mem_rvalid && mem_raddr <= MAX_ADDR)
            mem_rdata = {dmem[mem_raddr[13:0]], dmem[14'(mem_raddr + 32'd1)],
                         dmem[14'(mem_raddr + 32'd2)], dmem[14'(mem_raddr + 32'd3)]};
    end

    always @(posedge clk) begin
        if (mem_wvalid && mem_waddr <= MAX_ADDR) begin
            dmem[mem_waddr[13:0]]          <= mem_wdata[31:24];
            dmem[14'(mem_waddr + 32'd1)]   <= mem_wdata[23:16];
            dmem[14'(mem_waddr + 32'd2)]   <= mem_wdata[15:8];
            dmem[14'(mem_waddr + 32'd3)]   <= mem_wdata[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a % 4 != 0) || (a > MAX_ADDR);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return {rmem[a[13:0]], rmem[14'(a + 32'd1)], rmem[14'(a + 32'd2)], rmem[14'(a + 32'd3)]};
    endfunction

    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return {dmem[a[13:0]], dmem[14'(a + 32'd1)], dmem[14'(a + 32'd2)], dmem[14'(a + 32'd3)]};
    endfunction

    // Reference model: one access per grant, granted no sooner than two cycles after the
    // previous grant, ties alternate, the access lands in the cycle after the grant.
    initial begin
        int          last_acc = -100;
        int          last_win = 1;
        bit          p_v = 0;
        int          p_w = 0, p_cyc = 0;
        logic        p_we = 0;
        logic [31:0] p_addr = 0, p_wdata = 0, d;
        bit          e;
        exp_t        x;
        glog_t       g;
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                if (!rst) begin
                    chk("gnt_in_reset", 32'({gnt1, gnt0}), 32'h0);
                    if (p_v && cyc == p_cyc + 1) chk("wvalid_reset_busy", 32'(mem_wvalid), 32'h0);
                    p_v = 0;
                    last_acc = -100;
                    last_win = 1;
                end else begin
                    if (p_v && cyc == p_cyc + 1) begin
                        e = is_err(p_addr);
                        chk("mem_rvalid", 32'(mem_rvalid), 32'(!p_we && !e));
                        chk("mem_wvalid", 32'(mem_wvalid), 32'(p_we && !e));
                        chk("mem_raddr", mem_raddr, p_addr);
                        chk("mem_waddr", mem_waddr, p_addr);
                        chk("mem_wdata", mem_wdata, p_wdata);
                        d = 32'h0;
                        if (!e && p_we) begin
                            rmem[p_addr[13:0]]        = p_wdata[31:24];
                            rmem[14'(p_addr + 32'd1)] = p_wdata[23:16];
                            rmem[14'(p_addr + 32'd2)] = p_wdata[15:8];
                            rmem[14'(p_addr + 32'd3)] = p_wdata[7:0];
                        end else if (!e) begin
                            d = ref_rd(p_addr);
                        end
                        x.err = e; x.data = d; x.cyc = cyc + 1;
                        if (p_w == 1) q1.push_back(x); else q0.push_back(x);
                        p_v = 0;
                    end else begin
                        chk("mem_idle", 32'({mem_rvalid, mem_wvalid}), 32'h0);
                    end
                    if (cyc >= last_acc + 2 && (req0 || req1)) begin
                        p_w = (req0 && req1) ? 1 - last_win : (req1 ? 1 : 0);
                        chk("gnt", 32'({gnt1, gnt0}), (p_w == 1) ? 32'h2 : 32'h1);
                        p_we    = (p_w == 1) ? we1 : we0;
                        p_addr  = (p_w == 1) ? addr1 : addr0;
                        p_wdata = (p_w == 1) ? wdata1 : wdata0;
                        p_v = 1; p_cyc = cyc; last_win = p_w; last_acc = cyc;
                        g.w = p_w; g.cyc = cyc;
                        glog.push_back(g);
                    end else begin
                        chk("gnt_none", 32'({gnt1, gnt0}), 32'h0);
                    end
                end
            end
        end
    end

    // Response monitor: pops the owning port's queue whenever a response pulse appears.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                if (q0.size() > 0 && q0[0].cyc < cyc) begin
                    chk("rsp0_missing", 32'(q0[0].cyc), 32'(cyc));
                    void'(q0.pop_front());
                end
                if (q1.size() > 0 && q1[0].cyc < cyc) begin
                    chk("rsp1_missing", 32'(q1[0].cyc), 32'(cyc));
                    void'(q1.pop_front());
                end
                if (rsp_v0) begin
                    if (q0.size() == 0) begin
                        chk("rsp0_spurious", 32'(rsp_v0), 32'h0);
                    end else begin
                        x = q0.pop_front();
                        chk("rsp0_cyc", 32'(cyc), 32'(x.cyc));
                        chk("rsp0_err", 32'(rsp_err0), 32'(x.err));
                        chk("rsp0_data", rsp_data0, x.data);
                    end
                    chk("rsp1_quiet", {rsp_data1[31:2], rsp_v1, rsp_err1}, 32'h0);
                end
                if (rsp_v1) begin
                    if (q1.size() == 0) begin
                        chk("rsp1_spurious", 32'(rsp_v1), 32'h0);
                    end else begin
                        x = q1.pop_front();
                        chk("rsp1_cyc", 32'(cyc), 32'(x.cyc));
                        chk("rsp1_err", 32'(rsp_err1), 32'(x.err));
                        chk("rsp1_data", rsp_data1, x.data);
                    end
                    chk("rsp0_quiet", {rsp_data0[31:2], rsp_v0, rsp_err0}, 32'h0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic w, input logic [31:0] a, input logic [31:0] d);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt0) break;
            if (n == 39) chk("gnt0_timeout", 32'(gnt0), 32'h1);
        end
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
    endtask

    task automatic drv1(input logic w, input logic [31:0] a, input logic [31:0] d);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt1) break;
            if (n == 39) chk("gnt1_timeout", 32'(gnt1), 32'h1);
        end
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
    endtask

    task automatic do_reset();
        idle(3);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 15)) * 4;
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = MAX_ADDR;
        else if (r == 2) a = 32'(MEM_BYTES) + a;
        else if (r == 3) a = 32'hFFFF_FFFC;
        return a;
    endfunction

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            dmem[i] = 8'h0;
            rmem[i] = 8'h0;
        end
        rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        idle(3);
        chk("reset_rsp", 32'({rsp_v0, rsp_v1, rsp_err0, rsp_err1}), 32'h0);
        chk("reset_rsp_data", rsp_data0 | rsp_data1, 32'h0);
        chk("reset_mem_ctl", 32'({mem_rvalid, mem_wvalid, gnt0, gnt1}), 32'h0);
        chk("reset_mem_bus", mem_raddr | mem_waddr | mem_wdata, 32'h0);
        rst = 1'b1;

        // Write then read back through port 0.
        drv0(1'b1, 32'h10, 32'hDEADBEEF);
        drv0(1'b0, 32'h10, 32'h0);

        // Both ports held after reset: grants alternate starting at port 0.
        do_reset();
        glog.delete();
        fork
            begin repeat (2) drv0(1'b0, 32'h0, 32'h0); end
            begin repeat (2) drv1(1'b0, 32'h4, 32'h0); end
        join
        chk("rr_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            chk("rr_order", 32'(glog[i].w), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd2);
        end

        // Misaligned, just-out-of-range and last legal word.
        drv1(1'b0, 32'h13, 32'h0);
        drv1(1'b0, 32'd16384, 32'h0);
        drv1(1'b0, MAX_ADDR, 32'h0);

        // Reset asserted during the write's memory cycle.
        idle(2);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h11223344;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt1) break;
            if (n == 39) chk("gnt1_timeout", 32'(gnt1), 32'h1);
        end
        @(posedge clk); #1;
        req1 = 1'b0; rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(3);
        chk("reset_write_lost", dmem_rd(32'h20), ref_rd(32'h20));
        chk("reset_write_zero", dmem_rd(32'h20), 32'h0);

        // Port 1 alone, back-to-back.
        glog.delete();
        repeat (4) drv1(1'b0, 32'h10, 32'h0);
        for (int i = 1; i < glog.size(); i++)
            chk("b2b_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd2);

        // Cross-port visibility.
        idle(2);
        drv0(1'b1, 32'h04, 32'hA5A5A5A5);
        drv1(1'b0, 32'h04, 32'h0);
        idle(3);
        chk("xport_mem", dmem_rd(32'h04), 32'hA5A5A5A5);

        // Randomized traffic on both ports.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    drv0(1'($urandom), rand_addr(), $urandom);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    drv1(1'($urandom), rand_addr(), $urandom);
                end
            end
        join
        idle(6);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
